// File: rtl/adc_timing_pkg.sv
// adc_timing_pkg: shared types and sizing helpers for the ADC timing generator.
package adc_timing_pkg;

    // Controller states; WAIT_SYNC is only entered when ADC_EXT_SYNC_EN is defined.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Shortest period that fits conversion low time, word sync, all channel
    // slots and the new-sample strobe.
    function automatic int min_p(input int conv_low, input int n_chan);
        return conv_low + n_chan + 2;
    endfunction

    // Width of chan_idx, never below one bit.
    function automatic int chan_w(input int n_chan);
        return (n_chan <= 1) ? 1 : $clog2(n_chan);
    endfunction

endpackage

// File: rtl/adc_timing_gen_ref_clk_div.sv
// ref_clk_div: free-running toggle divider; ref_clk_o flips every REF_HALF
// cycles and is held low only by reset.
module ref_clk_div #(
    parameter int REF_HALF = 25
) (
    input  logic clk,
    input  logic reset,
    output logic ref_clk_o
);

    localparam int CNT_W = (REF_HALF <= 1) ? 1 : $clog2(REF_HALF);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_HALF - 1);

    logic [CNT_W-1:0] cnt;

    // Count REF_HALF cycles, then toggle the output and restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            ref_clk_o <= 1'b0;
        end else if (cnt == LAST) begin
            cnt       <= '0;
            ref_clk_o <= ~ref_clk_o;
        end else begin
            cnt       <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_timing_gen.sv
// adc_timing_gen: ADC conversion timing generator. Produces start-conversion,
// word-sync, channel-slot and new-sample strobes from a programmable period,
// plus a free-running reference clock.
// Optional feature macro: ADC_EXT_SYNC_EN (external resync input, WAIT_SYNC state).
module adc_timing_gen
    import adc_timing_pkg::*;
#(
    parameter int N_CHAN   = 8,
    parameter int DIV_W    = 16,
    parameter int CONV_LOW = 4,
    parameter int REF_HALF = 25
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [DIV_W-1:0]          sample_div,
`ifdef ADC_EXT_SYNC_EN
    input  logic                      ext_sync,
`endif
    output logic                      adc_start_conv_n,
    output logic                      adc_word_sync,
    output logic                      chan_valid,
    output logic [chan_w(N_CHAN)-1:0] chan_idx,
    output logic                      new_sample,
    output logic [31:0]               sample_cnt,
    output logic                      running,
    output logic                      cfg_err,
    output logic                      ref_clk_o
);

    localparam int CW   = chan_w(N_CHAN);
    // One extra bit so that P = sample_div + 1 never overflows.
    localparam int PH_W = DIV_W + 1;

    localparam logic [PH_W-1:0] MINP   = PH_W'(min_p(CONV_LOW, N_CHAN));
    localparam logic [PH_W-1:0] PH_WS  = PH_W'(CONV_LOW);
    localparam logic [PH_W-1:0] PH_C0  = PH_W'(CONV_LOW + 1);
    localparam logic [PH_W-1:0] PH_CN  = PH_W'(CONV_LOW + N_CHAN);
    localparam logic [PH_W-1:0] PH_NS  = PH_W'(CONV_LOW + N_CHAN + 1);
    localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);

    state_t          state, nxt_state;
    logic [PH_W-1:0] ph, nxt_ph;
    logic [PH_W-1:0] per, nxt_per;
    logic            nxt_cfg_err;
    logic            clr_cnt;

    logic [PH_W-1:0] req_per;
    logic            req_ok;

    logic            run_d;
    logic            start_n_d;
    logic            ws_d;
    logic            cv_d;
    logic [CW-1:0]   idx_d;
    logic            ns_d;
    logic [PH_W-1:0] rel_ph;

    assign req_per = {1'b0, sample_div} + PH_ONE;
    assign req_ok  = (req_per >= MINP);

`ifdef ADC_EXT_SYNC_EN
    logic [2:0] sync_q;
    logic       sync_edge;

    // Two-flop synchroniser, history flop and registered rising-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            sync_edge <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], ext_sync};
            sync_edge <= sync_q[1] & ~sync_q[2];
        end
    end
`endif

    // Next state, phase, latched period and error flag.
    always_comb begin
        nxt_state   = state;
        nxt_ph      = ph;
        nxt_per     = per;
        nxt_cfg_err = cfg_err;
        clr_cnt     = 1'b0;
        case (state)
            IDLE: begin
                nxt_ph = '0;
                if (enable) begin
                    if (req_ok) begin
                        nxt_per     = req_per;
                        nxt_cfg_err = 1'b0;
                        clr_cnt     = 1'b1;
`ifdef ADC_EXT_SYNC_EN
                        nxt_state   = WAIT_SYNC;
`else
                        nxt_state   = RUN;
`endif
                    end else begin
                        nxt_cfg_err = 1'b1;
                    end
                end
            end
`ifdef ADC_EXT_SYNC_EN
            WAIT_SYNC: begin
                nxt_ph = '0;
                if (!enable) begin
                    nxt_state = IDLE;
                end else if (sync_edge) begin
                    nxt_state = RUN;
                end
            end
`endif
            RUN: begin
                if (ph == per - PH_ONE) begin
                    // Wrap: stop cleanly, or pick up a new period if it is legal.
                    nxt_ph = '0;
                    if (!enable) begin
                        nxt_state = IDLE;
                    end else if (req_ok) begin
                        nxt_per = req_per;
                    end else begin
                        nxt_cfg_err = 1'b1;
                    end
                end
`ifdef ADC_EXT_SYNC_EN
                else if (sync_edge) begin
                    // Resync cuts the frame short before its new-sample strobe.
                    nxt_ph = '0;
                end
`endif
                else begin
                    nxt_ph = ph + PH_ONE;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_ph    = '0;
            end
        endcase
    end

    // Strobe decode from the next phase so the registered outputs line up
    // with the registered phase in the same cycle.
    always_comb begin
        run_d     = (nxt_state == RUN);
        start_n_d = ~(run_d && (nxt_ph < PH_WS));
        ws_d      = run_d && (nxt_ph == PH_WS);
        cv_d      = run_d && (nxt_ph >= PH_C0) && (nxt_ph <= PH_CN);
        rel_ph    = nxt_ph - PH_C0;
        idx_d     = cv_d ? rel_ph[CW-1:0] : '0;
        ns_d      = run_d && (nxt_ph == PH_NS);
    end

    // State, phase, period and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ph      <= '0;
            per     <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= nxt_state;
            ph      <= nxt_ph;
            per     <= nxt_per;
            cfg_err <= nxt_cfg_err;
        end
    end

    // Registered strobe outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_start_conv_n <= 1'b1;
            adc_word_sync    <= 1'b0;
            chan_valid       <= 1'b0;
            chan_idx         <= '0;
            new_sample       <= 1'b0;
            running          <= 1'b0;
        end else begin
            adc_start_conv_n <= start_n_d;
            adc_word_sync    <= ws_d;
            chan_valid       <= cv_d;
            chan_idx         <= idx_d;
            new_sample       <= ns_d;
            running          <= run_d;
        end
    end

    // Completed-sample counter: bumps the cycle after new_sample, wraps silently.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            sample_cnt <= '0;
        end else if (new_sample) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

    ref_clk_div #(
        .REF_HALF (REF_HALF)
    ) u_ref_clk_div (
        .clk       (clk),
        .reset     (reset),
        .ref_clk_o (ref_clk_o)
    );

endmodule

// File: tb/tb_adc_timing_gen.sv
// tb_adc_timing_gen: directed self-checking bench for adc_timing_gen
// (N_CHAN=4, CONV_LOW=4, REF_HALF=25).
module tb_adc_timing_gen;

    localparam int N_CHAN   = 4;
    localparam int DIV_W    = 16;
    localparam int CONV_LOW = 4;
    localparam int REF_HALF = 25;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [DIV_W-1:0] sample_div;
`ifdef ADC_EXT_SYNC_EN
    logic             ext_sync;
`endif
    logic             adc_start_conv_n;
    logic             adc_word_sync;
    logic             chan_valid;
    logic [1:0]       chan_idx;
    logic             new_sample;
    logic [31:0]      sample_cnt;
    logic             running;
    logic             cfg_err;
    logic             ref_clk_o;
    logic [5:0]       obs;

    int checks   = 0;
    int failures = 0;

    adc_timing_gen #(
        .N_CHAN   (N_CHAN),
        .DIV_W    (DIV_W),
        .CONV_LOW (CONV_LOW),
        .REF_HALF (REF_HALF)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .sample_div       (sample_div),
`ifdef ADC_EXT_SYNC_EN
        .ext_sync         (ext_sync),
`endif
        .adc_start_conv_n (adc_start_conv_n),
        .adc_word_sync    (adc_word_sync),
        .chan_valid       (chan_valid),
        .chan_idx         (chan_idx),
        .new_sample       (new_sample),
        .sample_cnt       (sample_cnt),
        .running          (running),
        .cfg_err          (cfg_err),
        .ref_clk_o        (ref_clk_o)
    );

    assign obs = {adc_start_conv_n, adc_word_sync, chan_valid, chan_idx, new_sample};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {start_n, word_sync, chan_valid, chan_idx, new_sample} at a RUN phase.
    function automatic logic [5:0] exp_vec(input int ph);
        logic sn, ws, cv, ns;
        logic [1:0] idx;
        sn  = !(ph < 4);
        ws  = (ph == 4);
        cv  = (ph >= 5) && (ph <= 8);
        idx = cv ? 2'(ph - 5) : 2'd0;
        ns  = (ph == 9);
        return {sn, ws, cv, idx, ns};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        enable = 1'b0;
`ifdef ADC_EXT_SYNC_EN
        ext_sync = 1'b0;
`endif
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        enable     = 1'b0;
        sample_div = 16'd19;
`ifdef ADC_EXT_SYNC_EN
        ext_sync   = 1'b0;
`endif
        tick;
        tick;
        checks++;
        if (obs !== 6'b100000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=%b", obs, 6'b100000);
        end
        checks++;
        if ({running, cfg_err, ref_clk_o} !== 3'b000 || sample_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_status got run=%b err=%b ref=%b cnt=%0d exp 0/0/0/0",
                     running, cfg_err, ref_clk_o, sample_cnt);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic_frame;
        do_reset;
        sample_div = 16'd19;
        enable     = 1'b1;
        tick;
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL basic_running got=%b exp=1", running);
        end
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (obs !== exp_vec(i % 20)) begin
                failures++;
                $display("FAIL basic_frame cyc=%0d got=%b exp=%b", i, obs, exp_vec(i % 20));
            end
            tick;
        end
        checks++;
        if (sample_cnt !== 32'd3 || obs !== exp_vec(0)) begin
            failures++;
            $display("FAIL basic_count got cnt=%0d strb=%b exp cnt=3 strb=%b",
                     sample_cnt, obs, exp_vec(0));
        end
    endtask

    task automatic test_invalid_period;
        do_reset;
        sample_div = 16'd8;
        enable     = 1'b1;
        tick;
        tick;
        checks++;
        if ({cfg_err, running, adc_start_conv_n} !== 3'b101) begin
            failures++;
            $display("FAIL invalid_reject got err/run/sn=%b exp=101",
                     {cfg_err, running, adc_start_conv_n});
        end
        enable = 1'b0;
        tick;
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL invalid_sticky got=%b exp=1", cfg_err);
        end
        sample_div = 16'd9;
        enable     = 1'b1;
        tick;
        checks++;
        if ({cfg_err, running} !== 2'b01) begin
            failures++;
            $display("FAIL invalid_restart got err/run=%b exp=01", {cfg_err, running});
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs !== exp_vec(i % 10)) begin
                failures++;
                $display("FAIL min_period cyc=%0d got=%b exp=%b", i, obs, exp_vec(i % 10));
            end
            tick;
        end
    endtask

    task automatic test_period_change_stop;
        int ns_seen;
        do_reset;
        sample_div = 16'd19;
        enable     = 1'b1;
        tick;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs !== exp_vec(i)) begin
                failures++;
                $display("FAIL chg_old_frame ph=%0d got=%b exp=%b", i, obs, exp_vec(i));
            end
            if (i == 3) sample_div = 16'd29;
            tick;
        end
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (obs !== exp_vec(i)) begin
                failures++;
                $display("FAIL chg_new_frame ph=%0d got=%b exp=%b", i, obs, exp_vec(i));
            end
            tick;
        end
        ns_seen = 0;
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (obs !== exp_vec(i)) begin
                failures++;
                $display("FAIL stop_frame ph=%0d got=%b exp=%b", i, obs, exp_vec(i));
            end
            if (i >= 7 && new_sample) ns_seen++;
            if (i == 7) enable = 1'b0;
            tick;
        end
        checks++;
        if (running !== 1'b0 || obs !== 6'b100000) begin
            failures++;
            $display("FAIL stop_idle got run=%b strb=%b exp run=0 strb=100000", running, obs);
        end
        checks++;
        if (ns_seen !== 1 || sample_cnt !== 32'd3) begin
            failures++;
            $display("FAIL stop_count got ns=%0d cnt=%0d exp ns=1 cnt=3", ns_seen, sample_cnt);
        end
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (running !== 1'b0 || adc_start_conv_n !== 1'b1) begin
            failures++;
            $display("FAIL stop_stays_idle got run=%b sn=%b exp 0/1", running, adc_start_conv_n);
        end
    endtask

    task automatic test_reset_mid_frame;
        do_reset;
        sample_div = 16'd19;
        enable     = 1'b1;
        tick;
        for (int i = 0; i < 26; i++) tick;
        checks++;
        if (obs !== exp_vec(6) || sample_cnt !== 32'd1) begin
            failures++;
            $display("FAIL mid_pre got strb=%b cnt=%0d exp strb=%b cnt=1", obs, sample_cnt, exp_vec(6));
        end
        reset = 1'b1;
        tick;
        checks++;
        if (obs !== 6'b100000 || sample_cnt !== 32'd0 || running !== 1'b0 || ref_clk_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got strb=%b cnt=%0d run=%b ref=%b exp 100000/0/0/0",
                     obs, sample_cnt, running, ref_clk_o);
        end
        enable = 1'b0;
        reset  = 1'b0;
        tick;
    endtask

    task automatic test_ref_clk;
        int n;
        int hi;
        int lo;
        do_reset;
        sample_div = 16'd19;
        n = 0;
        while (n < 100) begin
            tick;
            n++;
            if (ref_clk_o) break;
        end
        checks++;
        if (n !== 25) begin
            failures++;
            $display("FAIL ref_first_rise got=%0d exp=25", n);
        end
        for (int k = 0; k < 2; k++) begin
            hi = 0;
            while (ref_clk_o && hi < 200) begin
                enable = 1'($urandom_range(0, 1));
                tick;
                hi++;
            end
            lo = 0;
            while (!ref_clk_o && lo < 200) begin
                enable = 1'($urandom_range(0, 1));
                tick;
                lo++;
            end
            checks++;
            if (hi !== 25 || lo !== 25) begin
                failures++;
                $display("FAIL ref_period k=%0d got hi=%0d lo=%0d exp 25/25", k, hi, lo);
            end
        end
        enable = 1'b0;
    endtask

`ifdef ADC_EXT_SYNC_EN
    task automatic test_ext_sync;
        do_reset;
        sample_div = 16'd19;
        enable     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++;
            if ({adc_start_conv_n, running} !== 2'b10) begin
                failures++;
                $display("FAIL sync_wait cyc=%0d got sn/run=%b exp=10", i, {adc_start_conv_n, running});
            end
        end
        ext_sync = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++;
            if (adc_start_conv_n !== 1'b1) begin
                failures++;
                $display("FAIL sync_latency cyc=%0d got sn=%b exp=1", i, adc_start_conv_n);
            end
        end
        tick;
        checks++;
        if ({adc_start_conv_n, running} !== 2'b01) begin
            failures++;
            $display("FAIL sync_start got sn/run=%b exp=01", {adc_start_conv_n, running});
        end
        ext_sync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== exp_vec(i)) begin
                failures++;
                $display("FAIL sync_cut_frame ph=%0d got=%b exp=%b", i, obs, exp_vec(i));
            end
            if (i == 4) ext_sync = 1'b1;
            tick;
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs !== exp_vec(i)) begin
                failures++;
                $display("FAIL sync_resync ph=%0d got=%b exp=%b", i, obs, exp_vec(i));
            end
            if (i == 0) begin
                checks++;
                if (sample_cnt !== 32'd0) begin
                    failures++;
                    $display("FAIL sync_cnt_cut got=%0d exp=0", sample_cnt);
                end
            end
            tick;
        end
        checks++;
        if (sample_cnt !== 32'd1) begin
            failures++;
            $display("FAIL sync_cnt_after got=%0d exp=1", sample_cnt);
        end
        enable   = 1'b0;
        ext_sync = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset;
`ifdef ADC_EXT_SYNC_EN
        test_ext_sync;
`else
        test_basic_frame;
        test_invalid_period;
        test_period_change_stop;
        test_reset_mid_frame;
`endif
        test_ref_clk;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_timing_gen.md
# adc_timing_gen

Parametrised ADC conversion timing generator: the next generation of the system clock/strobe logic. It produces the ADC start-conversion, word-sync, per-channel and new-sample strobes from a runtime-programmable sample period and a generic channel count. It also provides a free-running timing reference clock. It sits in the 100 MHz fabric domain, between the clocking block and the ADC deserialiser / AXI-stream data producer.

## Interface
- `N_CHAN`, 8: ADC channels serialised per sample (1–64).
- `DIV_W`, 16: width of `sample_div`.
- `CONV_LOW`, 4: cycles `adc_start_conv_n` is held low (≥1).
- `REF_HALF`, 25: half-period in cycles of `ref_clk_o` (25 → 2 MHz at 100 MHz).
- `clk`  in  1  system clock. One clock only.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; run while high.
- `sample_div`  in  DIV_W  sample period minus 1, in cycles.
- `ext_sync`  in  1  external resync (only with `ADC_EXT_SYNC_EN`).
- `adc_start_conv_n`  out  1  conversion start, active low.
- `adc_word_sync`  out  1  one-cycle pulse before channel words.
- `chan_valid`  out  1  high during channel slots.
- `chan_idx`  out  $clog2(N_CHAN) (min 1)  current channel slot.
- `new_sample`  out  1  one-cycle pulse, sample frame complete.
- `sample_cnt`  out  32  completed samples since start.
- `running`  out  1  state is RUN.
- `cfg_err`  out  1  sticky: rejected period.
- `ref_clk_o`  out  1  free-running reference clock.

## Operation
- Period P = `sample_div`+1. MIN_P = CONV_LOW+N_CHAN+2. Phase counter `ph` runs 0..P-1 and then wraps.
- States:
  - IDLE → RUN when `enable`=1 and P ≥ MIN_P. P is latched, `ph`=0, and `sample_cnt` is cleared.
  - If P < MIN_P, set `cfg_err` and stay in IDLE.
  - With the macro, IDLE goes to WAIT_SYNC instead of RUN.
- RUN phase decode:
  - `ph` 0..CONV_LOW-1: `adc_start_conv_n`=0.
  - `ph`=CONV_LOW: `adc_word_sync`=1.
  - `ph` CONV_LOW+1..CONV_LOW+N_CHAN: `chan_valid`=1, `chan_idx`=`ph`-CONV_LOW-1.
  - `ph`=CONV_LOW+N_CHAN+1: `new_sample`=1, and `sample_cnt` increments on the next cycle.
  - At `ph`=P-1 the counter wraps to 0.
- A changed `sample_div` takes effect only at wrap. It is re-checked there: if invalid, set `cfg_err` and keep the old P.
- `enable` deasserted in RUN: the current period completes and `ph` reaches P-1. The next state is IDLE, so no partial frame is produced.
- `sample_cnt` wraps 2^32-1 → 0 silently.
- `cfg_err` clears only on `reset` or on a valid IDLE→RUN start.
- `ref_clk_o` toggles every REF_HALF cycles and ignores `enable`. It stops only in `reset`.

## Timing
- All outputs are registered. Strobes are decoded from the registered `ph`/state, so they align with the `ph` value in the same cycle.
- `enable` sampled high at edge t (state IDLE, P valid): `running`=1 and `adc_start_conv_n`=0 in cycle t+1.
- Reset values:
  - `adc_start_conv_n`=1, `ref_clk_o`=0.
  - All other outputs 0, state IDLE, `ph`=0.
- Reset mid-frame forces reset values at the next edge. No strobe completes.
- `enable` low and wrap in the same cycle: return to IDLE at that wrap.

## Configuration
- `ADC_EXT_SYNC_EN` defined:
  - `ext_sync` port exists and passes through a 2-FF synchroniser plus rising-edge detect. This adds 3 cycles of latency from the pin to the edge.
  - WAIT_SYNC → RUN on the detected edge.
  - An edge in RUN forces `ph`=0 on the next cycle. An unfinished frame emits no `new_sample`, and `sample_cnt` is unaffected.
- `ADC_EXT_SYNC_EN` undefined: no `ext_sync` port, no WAIT_SYNC state, and IDLE→RUN is direct.

## Structure
- Package `adc_timing_pkg` holds:
  - the state enum (IDLE, WAIT_SYNC, RUN);
  - the MIN_P constant function;
  - the `chan_idx` width function.
- Sub-module `ref_clk_div` holds the REF_HALF toggle divider (counter + toggle, reset only).

## Test plan
- Bench parameters: N_CHAN=4, CONV_LOW=4, `sample_div`=19.
- Basic frame: enable → `adc_start_conv_n` low on phases 0–3, `adc_word_sync` at 4, `chan_idx` 0..3 on phases 5–8, `new_sample` at 9, next frame 20 cycles later. `sample_cnt`=3 after 3 frames.
- Invalid period: `sample_div`=8 → `cfg_err`=1 and `running`=0. Then `sample_div`=9 with `enable` toggled → run starts and `cfg_err`=0.
- Period change and clean stop: `sample_div` 19→29 mid-frame → the current frame stays 20 cycles, the next is 30. `enable` dropped at phase 7 → frame finishes and IDLE at wrap, with exactly one more `new_sample`.
- Reset mid-frame at phase 6 → next cycle all reset values, `adc_start_conv_n`=1, `sample_cnt`=0.
- Reference clock: REF_HALF=25 → `ref_clk_o` period 50 cycles, unaffected by `enable`.
- With `ADC_EXT_SYNC_EN`:
  - no `adc_start_conv_n` activity until `ext_sync` rises; first low is 4 cycles after the pin edge (3-cycle synchroniser/edge-detect latency plus the WAIT_SYNC→RUN transition cycle);
  - an edge in RUN landing at phase 7 (i.e. pin edge 3 cycles earlier) gives `ph`=0 next cycle and no `new_sample` for the cut frame.
